// File: rtl/div_seq.sv
// div_seq: multi-cycle RV32M DIV/DIVU/REM/REMU sequencer (restoring division,
// one quotient bit per cycle). Optional build macro DIV_SEQ_FAST_PATH_EN lets
// divide-by-zero and signed overflow skip the iterative phase.
module div_seq #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start_i,
  input  logic            abort_i,
  input  logic [2:0]      op_i,
  input  logic [XLEN-1:0] dividend_i,
  input  logic [XLEN-1:0] divisor_i,
  input  logic [4:0]      wr_addr_i,
  output logic [XLEN-1:0] result_o,
  output logic            ready_o,
  output logic            busy_o,
  output logic [4:0]      wr_addr_o
);
  localparam int CW = $clog2(XLEN);
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t state, state_nxt;

  logic [CW-1:0]   cnt;
  logic [XLEN-1:0] dvd, dvs, rem, orig;  // dvd becomes the quotient as it shifts
  logic [2:0]      op_q;
  logic [4:0]      rd_q;
  logic            sa, sb, div0, ovf;

  // Issue decode: funct3 bit0 clear means signed op
  logic signed_in, accept, is_div0, is_ovf, fast;
  assign signed_in = ~op_i[0];
  assign accept    = (state == IDLE) && start_i && !abort_i && !ready_o;
  assign is_div0   = (divisor_i == '0);
  assign is_ovf    = signed_in && (dividend_i == MIN_NEG) && (&divisor_i);
`ifdef DIV_SEQ_FAST_PATH_EN
  assign fast = is_div0 | is_ovf;
`else
  assign fast = 1'b0;
`endif

  // busy covers the ready cycle too, so the issuer waits one more cycle
  assign busy_o = (state != IDLE) || ready_o;

  // Restoring step: XLEN+1 bit partial remainder so a large divisor never overflows
  logic [XLEN:0]   rem_sh, diff;
  logic            ge;
  assign rem_sh = {rem, dvd[XLEN-1]};
  assign diff   = rem_sh - {1'b0, dvs};
  assign ge     = (rem_sh >= {1'b0, dvs});

  // Sign fix and special-case result selection
  logic            neg_q, neg_r;
  logic [XLEN-1:0] q_fix, r_fix, q_sel, r_sel;
  assign neg_q = ~op_q[0] & (sa ^ sb);
  assign neg_r = ~op_q[0] & sa;
  assign q_fix = neg_q ? -dvd : dvd;
  assign r_fix = neg_r ? -rem : rem;
  assign q_sel = div0 ? '1 : (ovf ? MIN_NEG : q_fix);
  assign r_sel = div0 ? orig : (ovf ? '0 : r_fix);

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic; abort always returns to IDLE
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) state_nxt = fast ? DONE : CALC;
      CALC: begin
        if (abort_i)                      state_nxt = IDLE;
        else if (cnt == CW'(XLEN - 1))    state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: operand latch, iteration, result register
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0; dvd <= '0; dvs <= '0; rem <= '0; orig <= '0;
      op_q <= '0; rd_q <= '0; sa <= 1'b0; sb <= 1'b0; div0 <= 1'b0; ovf <= 1'b0;
      result_o <= '0; ready_o <= 1'b0; wr_addr_o <= '0;
    end else begin
      ready_o <= 1'b0;
      case (state)
        IDLE: if (accept) begin
          op_q <= op_i;
          rd_q <= wr_addr_i;
          sa   <= signed_in & dividend_i[XLEN-1];
          sb   <= signed_in & divisor_i[XLEN-1];
          div0 <= is_div0;
          ovf  <= is_ovf;
          orig <= dividend_i;
          dvd  <= (signed_in & dividend_i[XLEN-1]) ? -dividend_i : dividend_i;
          dvs  <= (signed_in & divisor_i[XLEN-1])  ? -divisor_i  : divisor_i;
          rem  <= '0;
          cnt  <= '0;
        end
        CALC: if (!abort_i) begin
          dvd <= {dvd[XLEN-2:0], ge};
          rem <= ge ? diff[XLEN-1:0] : rem_sh[XLEN-1:0];
          cnt <= cnt + CW'(1);
        end
        DONE: if (!abort_i) begin
          result_o  <= op_q[1] ? r_sel : q_sel;
          ready_o   <= 1'b1;
          wr_addr_o <= rd_q;
        end
        default: ;
      endcase
    end
  end
endmodule
